// File: rtl/scalar_multiplication.sv
// X-only Curve25519 scalar multiplication: x_q = x([k]P).
// A Montgomery ladder runs over all 255 bits of k. Fermat inversion Z^(p-2) then
// brings the result back to affine form. Every field product goes through one
// shared MSB-first shift-add modular multiplier. Add and sub take one cycle each.
//
// Fixed latency, counted in rising edges from reset release until done is high,
// where M = 1 + 255/MUL_BITS is the number of cycles per product:
//   2 (IDLE, LOAD) + 255*(1 cswap + 8 add/sub + 10*M) + 1 (final cswap)
//   + 255*2*M (square + multiply per exponent bit) + M (final product)
//   = 2298 + 3061*M
// With the default MUL_BITS=1, M=256 and the latency is 785,914 cycles for every k and x_p.
module scalar_multiplication #(
    parameter int MUL_BITS = 1   // multiplier bits retired per cycle; must divide 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [254:0] k,
    input  logic [254:0] x_p,
    output logic [254:0] x_q,
    output logic         done
);
    localparam logic [254:0] P     = {{247{1'b1}}, 8'hED};   // 2^255 - 19
    localparam logic [254:0] E_INV = {{247{1'b1}}, 8'hEB};   // p - 2
    localparam logic [254:0] A24   = 255'd121665;
    localparam int           ITER  = 255 / MUL_BITS;

    // register slots; slot 15 reads as A24 and, as a destination, writes x_q
    localparam logic [3:0] R_X1 = 4'd0,  R_X2 = 4'd1,  R_Z2 = 4'd2,  R_X3 = 4'd3;
    localparam logic [3:0] R_Z3 = 4'd4,  R_A  = 4'd5,  R_B  = 4'd6,  R_C  = 4'd7;
    localparam logic [3:0] R_D  = 4'd8,  R_AA = 4'd9,  R_BB = 4'd10, R_E  = 4'd11;
    localparam logic [3:0] R_DA = 4'd12, R_CB = 4'd13, R_EXT = 4'd15;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LADDER, S_FSWAP, S_INVERT, S_FINAL, S_DONE} state_t;
    typedef enum logic [2:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_SWAP} op_t;
    typedef struct packed {
        op_t        kind;
        logic [3:0] sa;
        logic [3:0] sb;
        logic [3:0] dst;
    } uop_t;

    state_t        state, nxt_state;
    logic [254:0]  r [16];
    logic [254:0]  k_r, xr, opa, opb;
    logic [254:0]  ma, mb, macc, mnext;
    logic          swap, busy, last, op_fin;
    logic [7:0]    i, cnt;
    logic [4:0]    uop;
    uop_t          u;

    function automatic uop_t mk(input op_t kd, input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] d);
        return '{kind: kd, sa: a, sb: b, dst: d};
    endfunction

    function automatic logic [254:0] fadd(input logic [254:0] a, input logic [254:0] b);
        logic [255:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[254:0];
    endfunction

    // a borrow means a < b, so adding p once lands back in [0, p-1]
    function automatic logic [254:0] fsub(input logic [254:0] a, input logic [254:0] b);
        logic [255:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[255]) d = d + {1'b0, P};
        return d[254:0];
    endfunction

    // one shift-add step: 2*acc + bit*a is < 3p, so two conditional subtractions suffice
    function automatic logic [254:0] mac(input logic [254:0] acc, input logic [254:0] a,
                                         input logic bit_b);
        logic [256:0] t;
        t = {1'b0, acc, 1'b0} + {2'b0, (bit_b ? a : 255'd0)};
        if (t >= {2'b0, P}) t = t - {2'b0, P};
        if (t >= {2'b0, P}) t = t - {2'b0, P};
        return t[254:0];
    endfunction

    assign xr     = (x_p >= P) ? x_p - P : x_p;
    assign opa    = (u.sa == R_EXT) ? A24 : r[u.sa];
    assign opb    = (u.sb == R_EXT) ? A24 : r[u.sb];
    assign op_fin = (u.kind != OP_MUL) || (busy && cnt == 8'd0);

    // unrolled multiplier iteration, MUL_BITS multiplier bits taken MSB-first
    always_comb begin
        mnext = macc;
        for (int j = 0; j < MUL_BITS; j++) mnext = mac(mnext, ma, mb[254-j]);
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= nxt_state;
    end

    // next-state logic
    always_comb begin
        nxt_state = state;
        case (state)
            S_IDLE:   nxt_state = S_LOAD;
            S_LOAD:   nxt_state = S_LADDER;
            S_LADDER: if (op_fin && last && i == 8'd0) nxt_state = S_FSWAP;
            S_FSWAP:  nxt_state = S_INVERT;
            S_INVERT: if (op_fin && last && i == 8'd0) nxt_state = S_FINAL;
            S_FINAL:  if (op_fin) nxt_state = S_DONE;
            default:  nxt_state = S_DONE;
        endcase
    end

    // micro-op decode: the ladder step, inversion bit and final product as op sequences
    always_comb begin
        u    = mk(OP_NONE, R_X1, R_X1, R_X1);
        last = 1'b0;
        case (state)
            S_LADDER: begin
                last = (uop == 5'd18);
                case (uop)
                    5'd0:    u = mk(OP_SWAP, R_X1, R_X1, R_X1);
                    5'd1:    u = mk(OP_ADD, R_X2, R_Z2, R_A);
                    5'd2:    u = mk(OP_SUB, R_X2, R_Z2, R_B);
                    5'd3:    u = mk(OP_ADD, R_X3, R_Z3, R_C);
                    5'd4:    u = mk(OP_SUB, R_X3, R_Z3, R_D);
                    5'd5:    u = mk(OP_MUL, R_A,  R_A,  R_AA);
                    5'd6:    u = mk(OP_MUL, R_B,  R_B,  R_BB);
                    5'd7:    u = mk(OP_MUL, R_D,  R_A,  R_DA);
                    5'd8:    u = mk(OP_MUL, R_C,  R_B,  R_CB);
                    5'd9:    u = mk(OP_SUB, R_AA, R_BB, R_E);
                    5'd10:   u = mk(OP_ADD, R_DA, R_CB, R_X3);
                    5'd11:   u = mk(OP_SUB, R_DA, R_CB, R_Z3);
                    5'd12:   u = mk(OP_MUL, R_X3, R_X3, R_X3);
                    5'd13:   u = mk(OP_MUL, R_Z3, R_Z3, R_Z3);
                    5'd14:   u = mk(OP_MUL, R_X1, R_Z3, R_Z3);
                    5'd15:   u = mk(OP_MUL, R_AA, R_BB, R_X2);
                    5'd16:   u = mk(OP_MUL, R_EXT, R_E, R_Z2);
                    5'd17:   u = mk(OP_ADD, R_AA, R_Z2, R_Z2);
                    default: u = mk(OP_MUL, R_E,  R_Z2, R_Z2);
                endcase
            end
            // always square and multiply; the product is kept only when the exponent bit is set
            S_INVERT: begin
                if (uop == 5'd0) u = mk(OP_MUL, R_A, R_A, R_A);
                else begin
                    u    = mk(OP_MUL, R_A, R_Z2, E_INV[i] ? R_A : R_B);
                    last = 1'b1;
                end
            end
            S_FINAL: u = mk(OP_MUL, R_X2, R_A, R_EXT);
            default: ;
        endcase
    end

    // datapath: load, cswap, add/sub, shared multiplier, sequencing counters, result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < 16; n++) r[n] <= '0;
            k_r  <= '0;
            swap <= 1'b0;
            i    <= '0;
            uop  <= '0;
            busy <= 1'b0;
            cnt  <= '0;
            ma   <= '0;
            mb   <= '0;
            macc <= '0;
            x_q  <= '0;
            done <= 1'b0;
        end else begin
            if (state == S_LOAD) begin
                k_r     <= k;
                r[R_X1] <= xr;
                r[R_X2] <= 255'd1;
                r[R_Z2] <= '0;
                r[R_X3] <= xr;
                r[R_Z3] <= 255'd1;
                swap    <= 1'b0;
                i       <= 8'd254;
                uop     <= '0;
            end
            if (state == S_FSWAP) begin
                if (swap) begin
                    r[R_X2] <= r[R_X3];
                    r[R_X3] <= r[R_X2];
                    r[R_Z2] <= r[R_Z3];
                    r[R_Z3] <= r[R_Z2];
                end
                r[R_A] <= 255'd1;
                i      <= 8'd254;
                uop    <= '0;
            end
            if (state == S_LADDER || state == S_INVERT || state == S_FINAL) begin
                case (u.kind)
                    OP_SWAP: begin
                        if (swap ^ k_r[i]) begin
                            r[R_X2] <= r[R_X3];
                            r[R_X3] <= r[R_X2];
                            r[R_Z2] <= r[R_Z3];
                            r[R_Z3] <= r[R_Z2];
                        end
                        swap <= k_r[i];
                    end
                    OP_ADD: r[u.dst] <= fadd(opa, opb);
                    OP_SUB: r[u.dst] <= fsub(opa, opb);
                    OP_MUL: begin
                        if (!busy) begin
                            ma   <= opa;
                            mb   <= opb;
                            macc <= '0;
                            cnt  <= 8'(ITER - 1);
                            busy <= 1'b1;
                        end else if (cnt == 8'd0) begin
                            busy <= 1'b0;
                            if (u.dst == R_EXT) begin
                                x_q  <= mnext;
                                done <= 1'b1;
                            end else begin
                                r[u.dst] <= mnext;
                            end
                        end else begin
                            macc <= mnext;
                            mb   <= mb << MUL_BITS;
                            cnt  <= cnt - 8'd1;
                        end
                    end
                    default: ;
                endcase
                if (op_fin) begin
                    if (last) begin
                        uop <= '0;
                        i   <= i - 8'd1;
                    end else begin
                        uop <= uop + 5'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_scalar_multiplication.sv
// Directed bench for scalar_multiplication. It uses a wide multiplier unroll to keep
// runs short, and a behavioural Curve25519 ladder model for the expected values.
module tb_scalar_multiplication;
    localparam int MB      = 255;
    localparam int M       = 1 + 255 / MB;
    localparam int EXP_CYC = 2298 + 3061 * M;
    localparam int BUDGET  = 20000;
    localparam logic [254:0] P  = {{247{1'b1}}, 8'hED};
    localparam logic [254:0] KA = 255'h3d1e9f47a2b86c05e71349d28b6af01c5e8327b9d4a61f70c95b382ea7d1640f;
    localparam logic [254:0] KB = 255'h7fa4c3195e2d08b76c1f93ae5047d2b81c6e3f95a0d72b4e8193c56f0ae2d7b1;
    localparam logic [254:0] XB = 255'h1b9e4d7a03c58f26e1d4b7092a6c3f85d0e7b4a1963c28f5e0b7d4a19c3e6f52;

    logic         clk, rst, done;
    logic [254:0] k, x_p, x_q;
    int           total, bad;

    scalar_multiplication #(.MUL_BITS(MB)) dut (
        .clk(clk), .rst(rst), .k(k), .x_p(x_p), .x_q(x_q), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference field model ----------------
    function automatic logic [254:0] m_mul(input logic [254:0] a, input logic [254:0] b);
        logic [509:0] t;
        t = {255'd0, a} * {255'd0, b};
        t = t % {255'd0, P};
        return t[254:0];
    endfunction

    function automatic logic [254:0] m_add(input logic [254:0] a, input logic [254:0] b);
        logic [255:0] s;
        s = ({1'b0, a} + {1'b0, b}) % {1'b0, P};
        return s[254:0];
    endfunction

    function automatic logic [254:0] m_sub(input logic [254:0] a, input logic [254:0] b);
        logic [255:0] s;
        s = ({1'b0, a} + {1'b0, P} - {1'b0, b}) % {1'b0, P};
        return s[254:0];
    endfunction

    function automatic logic [254:0] m_inv(input logic [254:0] z);
        logic [254:0] e, base, acc;
        e = P - 255'd2; base = z; acc = 255'd1;
        for (int t = 0; t < 255; t++) begin
            if (e[t]) acc = m_mul(acc, base);
            base = m_mul(base, base);
        end
        return acc;
    endfunction

    function automatic logic [254:0] m_ladder(input logic [254:0] kk, input logic [254:0] xx);
        logic [254:0] x1, x2, z2, x3, z3, ta, tb, aa, bb, e, c, d, da, cb, tmp;
        logic sw, kt;
        x1 = xx % P; x2 = 255'd1; z2 = '0; x3 = x1; z3 = 255'd1; sw = 1'b0;
        for (int t = 254; t >= 0; t--) begin
            kt = kk[t]; sw = sw ^ kt;
            if (sw) begin tmp = x2; x2 = x3; x3 = tmp; tmp = z2; z2 = z3; z3 = tmp; end
            sw = kt;
            ta = m_add(x2, z2); aa = m_mul(ta, ta);
            tb = m_sub(x2, z2); bb = m_mul(tb, tb);
            e  = m_sub(aa, bb);
            c  = m_add(x3, z3); d = m_sub(x3, z3);
            da = m_mul(d, ta);  cb = m_mul(c, tb);
            tmp = m_add(da, cb); x3 = m_mul(tmp, tmp);
            tmp = m_sub(da, cb); z3 = m_mul(x1, m_mul(tmp, tmp));
            x2 = m_mul(aa, bb);
            z2 = m_mul(e, m_add(aa, m_mul(255'd121665, e)));
        end
        if (sw) begin tmp = x2; x2 = x3; x3 = tmp; tmp = z2; z2 = z3; z3 = tmp; end
        return m_mul(x2, m_inv(z2));
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic start_run(input logic [254:0] kk, input logic [254:0] xx);
        @(negedge clk); rst = 1'b0; k = kk; x_p = xx;
        @(negedge clk); rst = 1'b1;
    endtask

    // counts rising edges until done; leak flags any nonzero x_q seen before done
    task automatic wait_done(output int cyc, output bit ok, output bit leak);
        cyc = 0; ok = 1'b0; leak = 1'b0;
        while (cyc < BUDGET && !ok) begin
            @(posedge clk); #1; cyc++;
            if (done === 1'b1) ok = 1'b1;
            else if (x_q !== '0) leak = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; k = '0; x_p = '0;
        #12;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
        total++; if (x_q !== '0) begin bad++; $display("FAIL reset_xq: got %h want 0", x_q); end
    endtask

    task automatic test_k_one();
        int cyc; bit ok, leak, sticky;
        start_run(255'd1, 255'd9);
        wait_done(cyc, ok, leak);
        total++; if (!ok) begin bad++; $display("FAIL k1_done: no done within %0d cycles", cyc); end
        total++; if (x_q !== 255'd9) begin bad++; $display("FAIL k1_xq: got %h want 9", x_q); end
        total++; if (cyc != EXP_CYC) begin bad++; $display("FAIL k1_latency: got %0d want %0d", cyc, EXP_CYC); end
        total++; if (leak) begin bad++; $display("FAIL k1_early_xq: x_q nonzero before done"); end
        sticky = 1'b1;
        repeat (20) begin @(posedge clk); #1; if (done !== 1'b1) sticky = 1'b0; end
        total++; if (!sticky) begin bad++; $display("FAIL k1_sticky: done dropped, got %0b want 1", done); end
    endtask

    task automatic test_k_zero();
        int cyc; bit ok, leak;
        start_run(255'd0, 255'd9);
        wait_done(cyc, ok, leak);
        total++; if (!ok) begin bad++; $display("FAIL k0_done: no done within %0d cycles", cyc); end
        total++; if (x_q !== '0) begin bad++; $display("FAIL k0_xq: got %h want 0", x_q); end
        total++; if (cyc != EXP_CYC) begin bad++; $display("FAIL k0_latency: got %0d want %0d", cyc, EXP_CYC); end
    endtask

    task automatic test_k_two();
        int cyc; bit ok, leak;
        logic [254:0] exp_x;
        exp_x = m_mul(255'd6400, m_inv(255'd157681440));
        start_run(255'd2, 255'd9);
        wait_done(cyc, ok, leak);
        total++; if (!ok) begin bad++; $display("FAIL k2_done: no done within %0d cycles", cyc); end
        total++; if (x_q !== exp_x) begin bad++; $display("FAIL k2_xq: got %h want %h", x_q, exp_x); end
        total++; if (cyc != EXP_CYC) begin bad++; $display("FAIL k2_latency: got %0d want %0d", cyc, EXP_CYC); end
    endtask

    task automatic test_async_reset_in_done();
        @(negedge clk); #2; rst = 1'b0; #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL async_rst_done: got %0b want 0", done); end
        total++; if (x_q !== '0) begin bad++; $display("FAIL async_rst_xq: got %h want 0", x_q); end
    endtask

    task automatic test_wide_inputs();
        int cyc; bit ok, leak;
        logic [254:0] xx, exp_x;
        xx = {255{1'b1}};
        exp_x = m_ladder(KA, xx);
        start_run(KA, xx);
        wait_done(cyc, ok, leak);
        total++; if (!ok) begin bad++; $display("FAIL wide_done: no done within %0d cycles", cyc); end
        total++; if (x_q !== exp_x) begin bad++; $display("FAIL wide_xq: got %h want %h", x_q, exp_x); end
        total++; if (cyc != EXP_CYC) begin bad++; $display("FAIL wide_latency: got %0d want %0d", cyc, EXP_CYC); end
        total++; if (leak) begin bad++; $display("FAIL wide_early_xq: x_q nonzero before done"); end
    endtask

    task automatic test_late_input_change();
        int cyc; bit ok, leak, held;
        logic [254:0] exp_x;
        exp_x = m_ladder(KB, XB);
        start_run(KB, XB);
        repeat (2) @(posedge clk);
        #1; k = ~KB; x_p = 255'd9;
        wait_done(cyc, ok, leak);
        cyc += 2;
        total++; if (!ok) begin bad++; $display("FAIL late_done: no done within %0d cycles", cyc); end
        total++; if (x_q !== exp_x) begin bad++; $display("FAIL late_xq: got %h want %h", x_q, exp_x); end
        total++; if (cyc != EXP_CYC) begin bad++; $display("FAIL late_latency: got %0d want %0d", cyc, EXP_CYC); end
        held = 1'b1;
        k = KA; x_p = XB;
        repeat (1000) begin
            @(posedge clk); #1;
            if (done !== 1'b1 || x_q !== exp_x) held = 1'b0;
        end
        total++; if (!held) begin bad++; $display("FAIL late_hold: done=%0b x_q=%h want 1 / %h", done, x_q, exp_x); end
    endtask

    task automatic test_abort_midway();
        int cyc; bit ok, leak;
        logic [254:0] exp_x;
        exp_x = m_ladder(KA, XB);
        start_run(KB, 255'd9);
        repeat (3000) @(posedge clk);
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_pre_done: got %0b want 0", done); end
        #2; rst = 1'b0; #1;
        total++; if (done !== 1'b0 || x_q !== '0) begin bad++; $display("FAIL abort_clear: done=%0b x_q=%h want 0/0", done, x_q); end
        start_run(KA, XB);
        wait_done(cyc, ok, leak);
        total++; if (!ok) begin bad++; $display("FAIL abort_done: no done within %0d cycles", cyc); end
        total++; if (x_q !== exp_x) begin bad++; $display("FAIL abort_xq: got %h want %h", x_q, exp_x); end
        total++; if (cyc != EXP_CYC) begin bad++; $display("FAIL abort_latency: got %0d want %0d", cyc, EXP_CYC); end
    endtask

    initial begin
        total = 0; bad = 0;
        test_reset();
        test_k_one();
        test_k_zero();
        test_k_two();
        test_async_reset_in_done();
        test_wide_inputs();
        test_late_input_change();
        test_abort_midway();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
